// File: rtl/rvb_pkg.sv
// Shared encodings and the decoded-operation enum for the bit-manipulation unit.
package rvb_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_LOGN   = 7'b0100000;
  localparam logic [6:0] F7_MINMAX = 7'b0000101;
  localparam logic [6:0] F7_ROT    = 7'b0110000;
  localparam logic [1:0] F2_R4     = 2'b11;
  localparam logic [5:0] F6_RORI   = 6'b011000;

  localparam logic [2:0] F3_ANDN  = 3'b111;
  localparam logic [2:0] F3_ORN   = 3'b110;
  localparam logic [2:0] F3_XNOR  = 3'b100;
  localparam logic [2:0] F3_MIN   = 3'b100;
  localparam logic [2:0] F3_MAX   = 3'b110;
  localparam logic [2:0] F3_MINU  = 3'b101;
  localparam logic [2:0] F3_MAXU  = 3'b111;
  localparam logic [2:0] F3_ROL   = 3'b001;
  localparam logic [2:0] F3_ROR   = 3'b101;
  localparam logic [2:0] F3_CMIX  = 3'b001;
  localparam logic [2:0] F3_CMOV  = 3'b101;
  localparam logic [2:0] F3_UNARY = 3'b001;
  localparam logic [2:0] F3_SHRI  = 3'b101;

  localparam logic [11:0] IMM_CLZ     = 12'h600;
  localparam logic [11:0] IMM_CTZ     = 12'h601;
  localparam logic [11:0] IMM_CPOP    = 12'h602;
  localparam logic [11:0] IMM_SEXTB   = 12'h604;
  localparam logic [11:0] IMM_SEXTH   = 12'h605;
  localparam logic [11:0] IMM_ORCB    = 12'h287;
  localparam logic [11:0] IMM_REV8_32 = 12'h698;
  localparam logic [11:0] IMM_REV8_64 = 12'h6B8;

  typedef enum logic [4:0] {
    OP_NONE, OP_ANDN, OP_ORN, OP_XNOR,
    OP_MIN, OP_MAX, OP_MINU, OP_MAXU,
    OP_ROL, OP_ROR, OP_RORI,
    OP_CMIX, OP_CMOV,
    OP_CLZ, OP_CTZ, OP_CPOP,
    OP_SEXTB, OP_SEXTH, OP_ORCB, OP_REV8
  } rvb_op_e;

endpackage

// File: rtl/rvb_bitcnt.sv
// Leading-zero, trailing-zero and population counts of one operand.
module rvb_bitcnt #(
  parameter int XLEN = 32,
  parameter int CW   = $clog2(XLEN) + 1
) (
  input  logic [XLEN-1:0] a,
  output logic [CW-1:0]   clz,
  output logic [CW-1:0]   ctz,
  output logic [CW-1:0]   cpop
);

  // Highest set bit wins the last assignment; all-zero input leaves XLEN.
  always_comb begin
    clz = CW'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (a[i]) clz = CW'(XLEN - 1 - i);
    end
  end

  // Lowest set bit wins by scanning downward; all-zero input leaves XLEN.
  always_comb begin
    ctz = CW'(XLEN);
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (a[i]) ctz = CW'(i);
    end
  end

  // Plain adder chain over all bits.
  always_comb begin
    cpop = '0;
    for (int i = 0; i < XLEN; i++) begin
      cpop = cpop + CW'(a[i]);
    end
  end

endmodule

// File: rtl/rvb_full.sv
// Bit-manipulation execute unit: decode, result mux and a one-entry output register.
module rvb_full
  import rvb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [XLEN-1:0] din_rs1,
  input  logic [XLEN-1:0] din_rs2,
  input  logic [XLEN-1:0] din_rs3,
  input  logic [31:0]     din_insn,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [XLEN-1:0] dout_rd
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam int NB  = XLEN / 8;
  localparam logic [11:0] IMM_REV8 = (XLEN == 64) ? IMM_REV8_64 : IMM_REV8_32;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [1:0]  funct2;
  logic [11:0] imm12;
  rvb_op_e     op;

  logic [SHW-1:0]  sh_amt;
  logic [SHW-1:0]  sh_neg;
  logic [XLEN-1:0] rotl;
  logic [XLEN-1:0] rotr;
  logic [XLEN-1:0] orcb;
  logic [XLEN-1:0] rev8;
  logic [XLEN-1:0] result;
  logic [CW-1:0]   clz_cnt;
  logic [CW-1:0]   ctz_cnt;
  logic [CW-1:0]   pop_cnt;
  logic            lt_s;
  logic            lt_u;
  logic            accept;

  // Register-number fields play no part in execution.
  logic unused_insn;
  assign unused_insn = ^{din_insn[19:15], din_insn[11:7]};

  assign opcode = din_insn[6:0];
  assign funct3 = din_insn[14:12];
  assign funct7 = din_insn[31:25];
  assign funct2 = din_insn[26:25];
  assign imm12  = din_insn[31:20];

  // Map the instruction word onto one operation; anything unmatched stays OP_NONE.
  always_comb begin
    op = OP_NONE;
    if (opcode == OPC_OP) begin
      if (funct7 == F7_LOGN) begin
        case (funct3)
          F3_ANDN: op = OP_ANDN;
          F3_ORN:  op = OP_ORN;
          F3_XNOR: op = OP_XNOR;
          default: op = OP_NONE;
        endcase
      end else if (funct7 == F7_MINMAX) begin
        case (funct3)
          F3_MIN:  op = OP_MIN;
          F3_MAX:  op = OP_MAX;
          F3_MINU: op = OP_MINU;
          F3_MAXU: op = OP_MAXU;
          default: op = OP_NONE;
        endcase
      end else if (funct7 == F7_ROT) begin
        case (funct3)
          F3_ROL:  op = OP_ROL;
          F3_ROR:  op = OP_ROR;
          default: op = OP_NONE;
        endcase
      end else if (funct2 == F2_R4) begin
        if (funct3 == F3_CMIX)      op = OP_CMIX;
        else if (funct3 == F3_CMOV) op = OP_CMOV;
      end
    end else if (opcode == OPC_OPIMM) begin
      if (funct3 == F3_UNARY) begin
        case (imm12)
          IMM_CLZ:   op = OP_CLZ;
          IMM_CTZ:   op = OP_CTZ;
          IMM_CPOP:  op = OP_CPOP;
          IMM_SEXTB: op = OP_SEXTB;
          IMM_SEXTH: op = OP_SEXTH;
          default:   op = OP_NONE;
        endcase
      end else if (funct3 == F3_SHRI) begin
        if (imm12 == IMM_ORCB)      op = OP_ORCB;
        else if (imm12 == IMM_REV8) op = OP_REV8;
        else if (din_insn[31:26] == F6_RORI && (XLEN == 64 || !din_insn[25]))
          op = OP_RORI;
      end
    end
  end

  // Rotates share one shifter pair; a zero amount makes the complementary
  // shift also zero, so both halves equal rs1 and the OR is still correct.
  assign sh_amt = (op == OP_RORI) ? din_insn[20 +: SHW] : din_rs2[SHW-1:0];
  assign sh_neg = -sh_amt;
  assign rotl   = (din_rs1 << sh_amt) | (din_rs1 >> sh_neg);
  assign rotr   = (din_rs1 >> sh_amt) | (din_rs1 << sh_neg);

  assign lt_s = $signed(din_rs1) < $signed(din_rs2);
  assign lt_u = din_rs1 < din_rs2;

  // Byte-wise OR-combine and byte reversal.
  always_comb begin
    orcb = '0;
    rev8 = '0;
    for (int i = 0; i < NB; i++) begin
      orcb[8*i +: 8] = {8{|din_rs1[8*i +: 8]}};
      rev8[8*i +: 8] = din_rs1[8*(NB-1-i) +: 8];
    end
  end

  rvb_bitcnt #(.XLEN(XLEN), .CW(CW)) u_bitcnt (
    .a    (din_rs1),
    .clz  (clz_cnt),
    .ctz  (ctz_cnt),
    .cpop (pop_cnt)
  );

  // Result select; unsupported encodings yield zero.
  always_comb begin
    result = '0;
    case (op)
      OP_ANDN:  result = din_rs1 & ~din_rs2;
      OP_ORN:   result = din_rs1 | ~din_rs2;
      OP_XNOR:  result = ~(din_rs1 ^ din_rs2);
      OP_MIN:   result = lt_s ? din_rs1 : din_rs2;
      OP_MAX:   result = lt_s ? din_rs2 : din_rs1;
      OP_MINU:  result = lt_u ? din_rs1 : din_rs2;
      OP_MAXU:  result = lt_u ? din_rs2 : din_rs1;
      OP_ROL:   result = rotl;
      OP_ROR:   result = rotr;
      OP_RORI:  result = rotr;
      OP_CMIX:  result = (din_rs1 & din_rs2) | (din_rs3 & ~din_rs2);
      OP_CMOV:  result = (din_rs2 != '0) ? din_rs1 : din_rs3;
      OP_CLZ:   result = {{(XLEN-CW){1'b0}}, clz_cnt};
      OP_CTZ:   result = {{(XLEN-CW){1'b0}}, ctz_cnt};
      OP_CPOP:  result = {{(XLEN-CW){1'b0}}, pop_cnt};
      OP_SEXTB: result = {{(XLEN-8){din_rs1[7]}}, din_rs1[7:0]};
      OP_SEXTH: result = {{(XLEN-16){din_rs1[15]}}, din_rs1[15:0]};
      OP_ORCB:  result = orcb;
      OP_REV8:  result = rev8;
      default:  result = '0;
    endcase
  end

  assign din_ready = !dout_valid || dout_ready;
  assign accept    = din_valid && din_ready;

  // Output register: load on accept, drop valid after a transfer with no refill, hold on stall.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dout_valid <= 1'b0;
      dout_rd    <= '0;
    end else if (accept) begin
      dout_valid <= 1'b1;
      dout_rd    <= result;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rvb_full.sv
// Self-checking bench for rvb_full: directed table, handshake sequences, random stream vs model.
module tb_rvb_full;

  logic        clock;
  logic        reset;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] din_rs1, din_rs2, din_rs3, din_insn;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_rd;

  logic        w_din_valid, w_din_ready, w_dout_valid, w_dout_ready;
  logic [63:0] w_rs1, w_rs2, w_rs3, w_dout_rd;
  logic [31:0] w_insn;

  int errors = 0;
  int checks = 0;

  rvb_full #(.XLEN(32)) u_dut (
    .clock(clock), .reset(reset),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_rs1(din_rs1), .din_rs2(din_rs2), .din_rs3(din_rs3), .din_insn(din_insn),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_rd(dout_rd)
  );

  rvb_full #(.XLEN(64)) u_dut64 (
    .clock(clock), .reset(reset),
    .din_valid(w_din_valid), .din_ready(w_din_ready),
    .din_rs1(w_rs1), .din_rs2(w_rs2), .din_rs3(w_rs3), .din_insn(w_insn),
    .dout_valid(w_dout_valid), .dout_ready(w_dout_ready), .dout_rd(w_dout_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd0, 5'd0, f3, 5'd0, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_r4(input logic [2:0] f3);
    return {5'd0, 2'b11, 5'd0, 5'd0, f3, 5'd0, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd0, f3, 5'd0, 7'b0010011};
  endfunction

  // Reference model for XLEN=32, written bit-by-bit from the instruction definitions.
  function automatic logic [31:0] model(input logic [31:0] insn, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic [31:0] r;
    int sh;
    int n;
    opc = insn[6:0];
    f3  = insn[14:12];
    f7  = insn[31:25];
    imm = insn[31:20];
    r   = 32'd0;
    if (opc == 7'h33) begin
      case ({f7, f3})
        {7'h20, 3'd7}: r = a & ~b;
        {7'h20, 3'd6}: r = a | ~b;
        {7'h20, 3'd4}: r = ~(a ^ b);
        {7'h05, 3'd4}: r = ($signed(a) < $signed(b)) ? a : b;
        {7'h05, 3'd6}: r = ($signed(a) > $signed(b)) ? a : b;
        {7'h05, 3'd5}: r = (a < b) ? a : b;
        {7'h05, 3'd7}: r = (a > b) ? a : b;
        {7'h30, 3'd1}: begin
          sh = int'(b[4:0]);
          for (int i = 0; i < 32; i++) r[(i + sh) % 32] = a[i];
        end
        {7'h30, 3'd5}: begin
          sh = int'(b[4:0]);
          for (int i = 0; i < 32; i++) r[i] = a[(i + sh) % 32];
        end
        default: begin
          if (f7[1:0] == 2'b11) begin
            if (f3 == 3'd1)      r = (a & b) | (c & ~b);
            else if (f3 == 3'd5) r = (b != 0) ? a : c;
          end
        end
      endcase
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1) begin
        case (imm)
          12'h600: begin n = 0; while (n < 32 && !a[31 - n]) n++; r = 32'(n); end
          12'h601: begin n = 0; while (n < 32 && !a[n]) n++; r = 32'(n); end
          12'h602: begin n = 0; for (int i = 0; i < 32; i++) n += int'(a[i]); r = 32'(n); end
          12'h604: r = 32'($signed(a[7:0]));
          12'h605: r = 32'($signed(a[15:0]));
          default: r = 32'd0;
        endcase
      end else if (f3 == 3'd5) begin
        if (imm == 12'h287) begin
          for (int k = 0; k < 4; k++)
            if (((a >> (8 * k)) & 32'hFF) != 0) r = r | (32'hFF << (8 * k));
        end else if (imm == 12'h698) begin
          r = {a[7:0], a[15:8], a[23:16], a[31:24]};
        end else if (insn[31:26] == 6'b011000 && !insn[25]) begin
          sh = int'(insn[24:20]);
          for (int i = 0; i < 32; i++) r[i] = a[(i + sh) % 32];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    int k;
    k = $urandom_range(0, 21);
    case (k)
      0:  w = enc_r(7'h20, 3'd7);
      1:  w = enc_r(7'h20, 3'd6);
      2:  w = enc_r(7'h20, 3'd4);
      3:  w = enc_r(7'h05, 3'd4);
      4:  w = enc_r(7'h05, 3'd6);
      5:  w = enc_r(7'h05, 3'd5);
      6:  w = enc_r(7'h05, 3'd7);
      7:  w = enc_r(7'h30, 3'd1);
      8:  w = enc_r(7'h30, 3'd5);
      9:  w = enc_r4(3'd1);
      10: w = enc_r4(3'd5);
      11: w = enc_i(12'h600, 3'd1);
      12: w = enc_i(12'h601, 3'd1);
      13: w = enc_i(12'h602, 3'd1);
      14: w = enc_i(12'h604, 3'd1);
      15: w = enc_i(12'h605, 3'd1);
      16: w = enc_i(12'h287, 3'd5);
      17: w = enc_i(12'h698, 3'd5);
      18: w = enc_i({6'b011000, 6'($urandom_range(0, 63))}, 3'd5);
      19: w = {25'($urandom), 7'b0110011};
      default: w = $urandom;
    endcase
    if (k < 19) begin
      w[19:15] = 5'($urandom);
      w[11:7]  = 5'($urandom);
    end
    return w;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 255));
      3: return 32'd1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input vec_t v);
    din_insn = v.insn;
    din_rs1  = v.rs1;
    din_rs2  = v.rs2;
    din_rs3  = v.rs3;
  endtask

  task automatic run64(input logic [31:0] insn, input logic [63:0] a, input logic [63:0] exp,
                       input string name);
    @(negedge clock);
    w_insn = insn;
    w_rs1 = a;
    w_din_valid = 1'b1;
    @(negedge clock);
    w_din_valid = 1'b0;
    chk({name, " valid"}, 64'(w_dout_valid), 64'd1);
    chk(name, w_dout_rd, exp);
  endtask

  logic [31:0] q[$];
  logic [31:0] held;
  int accepts;

  initial begin
    vecs[0]  = '{enc_r(7'h20, 3'd7), 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h00F000F0};
    vecs[1]  = '{enc_r(7'h20, 3'd4), 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF00FF00F};
    vecs[2]  = '{enc_r(7'h20, 3'd6), 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF0FFF0FF};
    vecs[3]  = '{enc_i(12'h600, 3'd1), 32'h00010000, 32'h0, 32'h0, 32'd15};
    vecs[4]  = '{enc_i(12'h601, 3'd1), 32'h0, 32'h0, 32'h0, 32'd32};
    vecs[5]  = '{enc_i(12'h602, 3'd1), 32'hFFFFFFFF, 32'h0, 32'h0, 32'd32};
    vecs[6]  = '{enc_i(12'h600, 3'd1), 32'h0, 32'h0, 32'h0, 32'd32};
    vecs[7]  = '{enc_r(7'h30, 3'd1), 32'h80000001, 32'd1, 32'h0, 32'h00000003};
    vecs[8]  = '{enc_r(7'h30, 3'd5), 32'h12345678, 32'd4, 32'h0, 32'h81234567};
    vecs[9]  = '{enc_i(12'h604, 3'd5), 32'h12345678, 32'h0, 32'h0, 32'h81234567};
    vecs[10] = '{enc_i(12'h698, 3'd5), 32'h11223344, 32'h0, 32'h0, 32'h44332211};
    vecs[11] = '{enc_i(12'h287, 3'd5), 32'h00010200, 32'h0, 32'h0, 32'h00FFFF00};
    vecs[12] = '{enc_r(7'h05, 3'd4), 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF};
    vecs[13] = '{enc_r(7'h05, 3'd5), 32'hFFFFFFFF, 32'd1, 32'h0, 32'd1};
    vecs[14] = '{enc_r(7'h05, 3'd6), 32'hFFFFFFFF, 32'd1, 32'h0, 32'd1};
    vecs[15] = '{enc_r(7'h05, 3'd7), 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF};
    vecs[16] = '{enc_r4(3'd1), 32'hAAAAAAAA, 32'hFFFF0000, 32'h55555555, 32'hAAAA5555};
    vecs[17] = '{enc_r4(3'd5), 32'h11111111, 32'h0, 32'h33333333, 32'h33333333};
    vecs[18] = '{enc_r4(3'd5), 32'h11111111, 32'h00000100, 32'h33333333, 32'h11111111};
    vecs[19] = '{enc_i(12'h604, 3'd1), 32'h00000080, 32'h0, 32'h0, 32'hFFFFFF80};
    vecs[20] = '{enc_i(12'h605, 3'd1), 32'h12348000, 32'h0, 32'h0, 32'hFFFF8000};
    vecs[21] = '{enc_i(12'h605, 3'd1), 32'hFFFF7FFF, 32'h0, 32'h0, 32'h00007FFF};
    vecs[22] = '{32'h00000013, 32'h00000005, 32'h0, 32'h0, 32'h0};
    vecs[23] = '{enc_i(12'h621, 3'd5), 32'h12345678, 32'h0, 32'h0, 32'h0};
    vecs[24] = '{enc_i(12'h6B8, 3'd5), 32'h11223344, 32'h0, 32'h0, 32'h0};
    vecs[25] = '{enc_r(7'h30, 3'd1), 32'h12345678, 32'h00000020, 32'h0, 32'h12345678};

    reset = 1'b0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    din_insn = 32'd0; din_rs1 = 32'd0; din_rs2 = 32'd0; din_rs3 = 32'd0;
    w_din_valid = 1'b0; w_dout_ready = 1'b1;
    w_insn = 32'd0; w_rs1 = 64'd0; w_rs2 = 64'd0; w_rs3 = 64'd0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    chk("reset dout_valid", 64'(dout_valid), 64'd0);
    chk("reset dout_rd", 64'(dout_rd), 64'd0);
    chk("reset din_ready", 64'(din_ready), 64'd1);

    // Directed table, one instruction at a time.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      din_valid = 1'b1;
      @(negedge clock);
      din_valid = 1'b0;
      chk($sformatf("vec%0d valid", i), 64'(dout_valid), 64'd1);
      chk($sformatf("vec%0d insn=%h", i, vecs[i].insn), 64'(dout_rd), 64'(vecs[i].exp));
    end
    @(negedge clock);
    chk("idle after transfer", 64'(dout_valid), 64'd0);

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        drive(vecs[i]);
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      #1;
      chk($sformatf("b2b din_ready %0d", i), 64'(din_ready), 64'd1);
      if (i > 0) begin
        chk($sformatf("b2b valid %0d", i), 64'(dout_valid), 64'd1);
        chk($sformatf("b2b rd %0d", i), 64'(dout_rd), 64'(vecs[i-1].exp));
      end
      @(negedge clock);
    end

    // Held valid with a stalled consumer: exactly one accept, output frozen.
    drive(vecs[0]);
    din_valid = 1'b1;
    dout_ready = 1'b0;
    accepts = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) drive(vecs[1]);
      #1;
      if (din_ready) accepts++;
      if (k >= 1) begin
        chk($sformatf("stall valid %0d", k), 64'(dout_valid), 64'd1);
        chk($sformatf("stall rd %0d", k), 64'(dout_rd), 64'h00F000F0);
        chk($sformatf("stall din_ready %0d", k), 64'(din_ready), 64'd0);
      end
      @(negedge clock);
    end
    chk("stall accept count", 64'(accepts), 64'd1);
    din_valid = 1'b0;
    dout_ready = 1'b1;
    @(negedge clock);
    chk("stall release", 64'(dout_valid), 64'd0);

    // Reset asserted while a result is stalled.
    drive(vecs[1]);
    din_valid = 1'b1;
    dout_ready = 1'b0;
    @(negedge clock);
    din_valid = 1'b0;
    chk("pre-reset valid", 64'(dout_valid), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("mid-stall reset valid", 64'(dout_valid), 64'd0);
    chk("mid-stall reset rd", 64'(dout_rd), 64'd0);
    reset = 1'b1;
    dout_ready = 1'b1;
    @(negedge clock);

    // XLEN=64 instance.
    run64(enc_i(12'h600, 3'd1), 64'd1, 64'd63, "x64 clz 1");
    run64(enc_i(12'h601, 3'd1), 64'd0, 64'd64, "x64 ctz 0");
    run64(enc_i(12'h6B8, 3'd5), 64'h0102030405060708, 64'h0807060504030201, "x64 rev8");
    run64(enc_i(12'h624, 3'd5), 64'h123456789ABCDEF0, 64'h89ABCDEF01234567, "x64 rori 36");
    run64(enc_i(12'h698, 3'd5), 64'h0102030405060708, 64'd0, "x64 rev8 32-form");

    // Random stream with random backpressure, scored against the model.
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      din_insn = rand_insn();
      din_rs1 = rand_op();
      din_rs2 = rand_op();
      din_rs3 = rand_op();
      din_valid = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rand din_ready", 64'(din_ready), 64'(!dout_valid || dout_ready));
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand spurious output: got %h expected none", dout_rd);
        end else begin
          held = q.pop_front();
          chk("rand result", 64'(dout_rd), 64'(held));
        end
      end
      if (din_valid && din_ready) q.push_back(model(din_insn, din_rs1, din_rs2, din_rs3));
      @(negedge clock);
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      if (dout_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drain spurious output: got %h expected none", dout_rd);
        end else begin
          held = q.pop_front();
          chk("drain result", 64'(dout_rd), 64'(held));
        end
      end
      @(negedge clock);
    end
    chk("drain queue empty", 64'(q.size()), 64'd0);
    chk("drain valid low", 64'(dout_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
